ex_alu_stage: RTL and testbench
===============================

// Module: ex_alu_stage
// PURPOSE
//  Execute-stage ALU with an EX/MEM pipeline register and the processor flag register.
//  Builds a 16-bit saturating adder from four chained carry_look_ahead 4-bit slices.
//  The same slices, in pad mode, perform PADDSB (four independent saturating nibble adds).
//  Sits between the ID/EX register and the memory stage; drives flags to branch logic.
// PARAMETERS
//  WIDTH   16   datapath width; must be 16 (four 4-bit slices), other values unsupported
// PORTS
//  clk          in   1   system clock, all state on rising edge
//  rst_n        in   1   asynchronous active-low reset
//  ex_valid     in   1   operands/op on ex_* are a live instruction
//  ex_op        in   2   00 ADD, 01 SUB, 10 XOR, 11 PADDSB
//  ex_a         in   16  operand A (rs)
//  ex_b         in   16  operand B (rt)
//  stall        in   1   hold EX/MEM register and flags this cycle
//  flush        in   1   kill the instruction entering EX/MEM this cycle
//  mem_valid    out  1   registered: mem_result holds a live instruction
//  mem_result   out  16  registered ALU result
//  flag_n       out  1   registered negative flag
//  flag_z       out  1   registered zero flag
//  flag_v       out  1   registered overflow flag
// BEHAVIOUR
//  Reset (rst_n=0, async, any time incl. mid-operation)
//   - mem_valid=0, mem_result=16'h0000, flag_n=0, flag_z=0, flag_v=0.
//   - Takes effect immediately; first capture on first rising clk after deassertion.
//  Latency: 1 cycle; ex_* sampled at edge k appear on mem_* and flags after edge k.
//  Capture condition: cap = ex_valid & ~stall & ~flush.
//  Register update priority, evaluated each rising edge:
//   1. flush=1  -> mem_valid<=0; mem_result and flags hold. flush beats stall.
//   2. stall=1  -> mem_valid, mem_result and flags all hold.
//   3. else     -> mem_valid<=ex_valid; if ex_valid, mem_result<=res; flags per op.
//  ADD: slices pad=0; slice0 cin=0; slice i cin = slice i-1 Cout; raw = A+B mod 2^16.
//   - ovf = (A[15]==B[15]) & (raw[15]!=A[15]).
//   - res = ovf ? (A[15] ? 16'h8000 : 16'h7FFF) : raw.
//  SUB: slices see B' = ~B; slice0 cin=1; raw = A + ~B + 1.
//   - ovf = (A[15]!=B[15]) & (raw[15]!=A[15]).
//   - Saturation is the same as ADD, keyed on A[15].
//  XOR: res = A ^ B; ovf = 0.
//  PADDSB: all slices pad=1, carry chain broken, every slice cin=0.
//   - Each nibble saturates independently to 4'h7 or 4'h8 (result taken from slice Sum).
//  Flag update, only when cap=1:
//   - ADD/SUB: flag_n<=res[15], flag_z<=(res==0), flag_v<=ovf.
//     N and Z are taken after saturation; V is taken before saturation.
//   - XOR: flag_z<=(res==0); flag_n and flag_v hold.
//   - PADDSB: no flag changes.
//   - ex_valid=0 (bubble): no flag changes.
//  Boundary cases
//   - 16'h8000-16'h8000 gives 0 with Z=1 and V=0.
//   - 16'h0000-16'h8000 saturates to 16'h7FFF with V=1.
//   - Carry out of bit 15 is discarded and never sets a flag.
//   - stall and flush both high: flush behaviour (bubble inserted, flags hold).
//   - mem_result is not cleared on flush; consumers qualify it with mem_valid.
// TESTING
//  ADD 7FFF+0001 -> mem_result=7FFF, N=0 Z=0 V=1, mem_valid=1 one cycle later.
//  SUB 8000-0001 -> 8000 N=1 V=1; SUB 1234-1234 -> 0000 Z=1 V=0 N=0.
//  PADDSB 7172+1111 -> 7273; PADDSB 8888+8888 -> 8888; flags unchanged from prior.
//  XOR AAAA^AAAA after an ADD that set V=1 -> 0000, Z=1, V remains 1, N held.
//  ADD then stall 3 cycles with new ex_* -> mem_* and flags frozen; ADD+flush -> mem_valid=0.
//  rst_n low mid-stream -> all outputs 0 asynchronously; first post-reset op lands 1 cycle later.

Source files
------------

// File: rtl/ex_alu_stage_if.sv
// EX-stage bus: operands/control from ID/EX towards the ALU, and the
// registered EX/MEM result plus processor flags back out.
interface ex_alu_stage_if #(
    parameter int WIDTH = 16
);
    logic             ex_valid;
    logic [1:0]       ex_op;
    logic [WIDTH-1:0] ex_a;
    logic [WIDTH-1:0] ex_b;
    logic             stall;
    logic             flush;
    logic             mem_valid;
    logic [WIDTH-1:0] mem_result;
    logic             flag_n;
    logic             flag_z;
    logic             flag_v;

    // Pipeline control side (ID/EX register, hazard unit)
    modport master (
        output ex_valid, ex_op, ex_a, ex_b, stall, flush,
        input  mem_valid, mem_result, flag_n, flag_z, flag_v
    );

    // ALU stage side
    modport slave (
        input  ex_valid, ex_op, ex_a, ex_b, stall, flush,
        output mem_valid, mem_result, flag_n, flag_z, flag_v
    );
endinterface

// File: rtl/ex_alu_stage.sv
// Execute-stage ALU: 16-bit saturating add/sub built from four chained
// 4-bit carry-lookahead slices, nibble-wise saturating PADDSB using the same
// slices with the chain broken, XOR, the EX/MEM register and the N/Z/V flags.

// 4-bit carry-lookahead slice. In pad mode the nibble result saturates to
// 4'h7 / 4'h8 on signed overflow; otherwise it is a plain modular sum.
module carry_look_ahead (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    input  logic       pad,
    output logic [3:0] sum,
    output logic       cout
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    logic [3:0] raw;
    logic       nib_ovf;

    // Generate/propagate lookahead carries and the saturating nibble result
    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);
        raw     = p ^ c[3:0];
        nib_ovf = (a[3] == b[3]) && (raw[3] != a[3]);
        cout    = c[4];
        sum     = raw;
        if (pad && nib_ovf) begin
            sum = a[3] ? 4'h8 : 4'h7;
        end
    end
endmodule

module ex_alu_stage #(
    parameter int WIDTH = 16   // only 16 is supported (four 4-bit slices)
) (
    input  logic            clk,
    input  logic            rst_n,
    ex_alu_stage_if.slave   bus
);
    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_PADD = 2'b11;

    logic             is_sub;
    logic             is_pad;
    logic [WIDTH-1:0] b_eff;
    logic [4:0]       carry;
    logic [WIDTH-1:0] slice_sum;
    logic             carry_into_msb;
    logic             ovf;
    logic [WIDTH-1:0] res;

    logic             mem_valid_reg;
    logic [WIDTH-1:0] mem_result_reg;
    logic             flag_n_reg;
    logic             flag_z_reg;
    logic             flag_v_reg;

    assign is_sub   = (bus.ex_op == OP_SUB);
    assign is_pad   = (bus.ex_op == OP_PADD);
    assign b_eff    = is_sub ? ~bus.ex_b : bus.ex_b;
    // Subtraction is A + ~B + 1, so the chain starts with carry-in 1
    assign carry[0] = is_sub;

    // Four slices; PADDSB breaks the chain by forcing every cin to 0
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_slice
            carry_look_ahead u_cla (
                .a    (bus.ex_a[gi*4 +: 4]),
                .b    (b_eff[gi*4 +: 4]),
                .cin  (is_pad ? 1'b0 : carry[gi]),
                .pad  (is_pad),
                .sum  (slice_sum[gi*4 +: 4]),
                .cout (carry[gi+1])
            );
        end
    endgenerate

    // Signed overflow = carry into bit 15 XOR carry out of bit 15; the
    // carry out itself is otherwise discarded.
    assign carry_into_msb = slice_sum[WIDTH-1] ^ bus.ex_a[WIDTH-1] ^ b_eff[WIDTH-1];
    assign ovf            = carry[4] ^ carry_into_msb;

    // Result select: add/sub saturate on overflow keyed on the sign of A
    always_comb begin
        res = slice_sum;
        unique case (bus.ex_op)
            OP_ADD, OP_SUB: begin
                if (ovf) begin
                    res = bus.ex_a[WIDTH-1] ? 16'h8000 : 16'h7FFF;
                end
            end
            OP_XOR:  res = bus.ex_a ^ bus.ex_b;
            OP_PADD: res = slice_sum;
            default: res = slice_sum;
        endcase
    end

    // EX/MEM register and flags: flush beats stall, flags move only on capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_valid_reg  <= 1'b0;
            mem_result_reg <= '0;
            flag_n_reg     <= 1'b0;
            flag_z_reg     <= 1'b0;
            flag_v_reg     <= 1'b0;
        end else if (bus.flush) begin
            mem_valid_reg <= 1'b0;
        end else if (!bus.stall) begin
            mem_valid_reg <= bus.ex_valid;
            if (bus.ex_valid) begin
                mem_result_reg <= res;
                if (bus.ex_op == OP_ADD || bus.ex_op == OP_SUB) begin
                    flag_n_reg <= res[WIDTH-1];
                    flag_z_reg <= (res == '0);
                    flag_v_reg <= ovf;
                end else if (bus.ex_op == OP_XOR) begin
                    flag_z_reg <= (res == '0);
                end
            end
        end
    end

    assign bus.mem_valid  = mem_valid_reg;
    assign bus.mem_result = mem_result_reg;
    assign bus.flag_n     = flag_n_reg;
    assign bus.flag_z     = flag_z_reg;
    assign bus.flag_v     = flag_v_reg;
endmodule

// File: tb/tb_ex_alu_stage.sv
// Directed bench for ex_alu_stage: a vector table applied back-to-back,
// then hand sequences for stall, flush, bubble and asynchronous reset.
module tb_ex_alu_stage;
    logic clk;
    logic rst_n;

    ex_alu_stage_if #(.WIDTH(16)) bus ();

    ex_alu_stage #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic        n;
        logic        z;
        logic        v;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs [NVEC];

    int tests;
    int failed;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic v, input logic [15:0] r,
                             input logic n, input logic z, input logic ov);
        check({tag, " mem_valid"},  {15'd0, bus.mem_valid}, {15'd0, v});
        check({tag, " mem_result"}, bus.mem_result, r);
        check({tag, " flag_n"},     {15'd0, bus.flag_n}, {15'd0, n});
        check({tag, " flag_z"},     {15'd0, bus.flag_z}, {15'd0, z});
        check({tag, " flag_v"},     {15'd0, bus.flag_v}, {15'd0, ov});
    endtask

    // Called at a negedge: drive, cross one rising edge, return at next negedge
    task automatic step(input logic vld, input logic [1:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic stl, input logic fl);
        bus.ex_valid = vld;
        bus.ex_op    = op;
        bus.ex_a     = a;
        bus.ex_b     = b;
        bus.stall    = stl;
        bus.flush    = fl;
        @(posedge clk);
        @(negedge clk);
        $display("[TB] v=%0b op=%0d a=%h b=%h stall=%0b flush=%0b -> mem_valid=%0b res=%h N=%0b Z=%0b V=%0b",
                 vld, op, a, b, stl, fl, bus.mem_valid, bus.mem_result,
                 bus.flag_n, bus.flag_z, bus.flag_v);
    endtask

    initial begin
        tests  = 0;
        failed = 0;

        //           op     a         b         res       n     z     v
        vecs[0]  = '{2'b00, 16'h7FFF, 16'h0001, 16'h7FFF, 1'b0, 1'b0, 1'b1};
        vecs[1]  = '{2'b10, 16'hAAAA, 16'hAAAA, 16'h0000, 1'b0, 1'b1, 1'b1};
        vecs[2]  = '{2'b01, 16'h8000, 16'h0001, 16'h8000, 1'b1, 1'b0, 1'b1};
        vecs[3]  = '{2'b11, 16'h7172, 16'h1111, 16'h7273, 1'b1, 1'b0, 1'b1};
        vecs[4]  = '{2'b11, 16'h8888, 16'h8888, 16'h8888, 1'b1, 1'b0, 1'b1};
        vecs[5]  = '{2'b01, 16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{2'b01, 16'h8000, 16'h8000, 16'h0000, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{2'b01, 16'h0000, 16'h8000, 16'h7FFF, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{2'b00, 16'h8000, 16'h8000, 16'h8000, 1'b1, 1'b0, 1'b1};
        vecs[9]  = '{2'b00, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{2'b00, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{2'b10, 16'hF0F0, 16'h0F0F, 16'hFFFF, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{2'b01, 16'h0005, 16'h0007, 16'hFFFE, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{2'b10, 16'h8000, 16'h0000, 16'h8000, 1'b1, 1'b0, 1'b0};

        // Reset state, checked before any clock edge
        rst_n        = 1'b0;
        bus.ex_valid = 1'b0;
        bus.ex_op    = 2'b00;
        bus.ex_a     = 16'h0;
        bus.ex_b     = 16'h0;
        bus.stall    = 1'b0;
        bus.flush    = 1'b0;
        #3;
        check_all("reset", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Vector table, back-to-back with one-cycle latency
        for (int i = 0; i < NVEC; i++) begin
            step(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, 1'b0);
            check_all($sformatf("vec%0d", i), 1'b1, vecs[i].res,
                      vecs[i].n, vecs[i].z, vecs[i].v);
        end

        // ADD then stall three cycles with a different live op on ex_*
        step(1'b1, 2'b00, 16'h1111, 16'h2222, 1'b0, 1'b0);
        check_all("add_pre_stall", 1'b1, 16'h3333, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 2'b00, 16'h7FFF, 16'h7FFF, 1'b1, 1'b0);
            check_all($sformatf("stall%0d", k), 1'b1, 16'h3333, 1'b0, 1'b0, 1'b0);
        end

        // Flush kills the op: bubble, result and flags hold
        step(1'b1, 2'b00, 16'h8000, 16'h8000, 1'b0, 1'b1);
        check_all("flush", 1'b0, 16'h3333, 1'b0, 1'b0, 1'b0);

        // Flush and stall together behave as flush
        step(1'b1, 2'b00, 16'h0001, 16'h0001, 1'b0, 1'b0);
        check_all("add_pre_both", 1'b1, 16'h0002, 1'b0, 1'b0, 1'b0);
        step(1'b1, 2'b01, 16'h0000, 16'h0001, 1'b1, 1'b1);
        check_all("stall_flush", 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);

        // Bubble (ex_valid=0): nothing captured, flags hold
        step(1'b1, 2'b00, 16'h0001, 16'h0001, 1'b0, 1'b0);
        step(1'b0, 2'b01, 16'h0000, 16'h8000, 1'b0, 1'b0);
        check_all("bubble", 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);

        // Async reset mid-stream, between clock edges
        step(1'b1, 2'b00, 16'h8000, 16'hFFFF, 1'b0, 1'b0);
        check_all("pre_reset", 1'b1, 16'h8000, 1'b1, 1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("async_reset", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n        = 1'b1;
        bus.ex_valid = 1'b1;
        bus.ex_op    = 2'b00;
        bus.ex_a     = 16'h0001;
        bus.ex_b     = 16'h0002;
        #1;
        check_all("post_reset_pre_edge", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check_all("post_reset_first_op", 1'b1, 16'h0003, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
